// File: rtl/alu_vec_pkg.sv
// Shared constants for the Q7.8 vector ALU lane: opcodes, flag bit positions, widths.
package alu_vec_pkg;

   localparam int Q78_W    = 16;
   localparam int Q78_FRAC = 8;

   localparam logic [2:0] OP_MUL = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SET = 3'b111;

   localparam int FLG_V = 3;
   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_C = 0;

endpackage

// File: rtl/alu_vec_aux_q78_mul.sv
// Combinational signed fixed-point multiply: truncated (floor) product plus range overflow.
module q78_mul
   import alu_vec_pkg::*;
#(
   parameter int W    = Q78_W,
   parameter int FRAC = Q78_FRAC
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] product,
   output logic         ovf
);

   logic signed [2*W-1:0] p;
   logic [FRAC-1:0]       unused_frac;
   logic [W-FRAC:0]       top_bits;

   assign p           = $signed(a) * $signed(b);
   assign product     = p[W+FRAC-1:FRAC];
   assign unused_frac = p[FRAC-1:0];
   // Bits above the kept window must all copy its sign bit, otherwise the value is out of range.
   assign top_bits    = p[2*W-1:W+FRAC-1];
   assign ovf         = !((&top_bits) || !(|top_bits));

endmodule

// File: rtl/alu_vec_aux.sv
// One Q7.8 vector ALU lane: MUL/SUB/ADD/SET with NZCV flags, registered with 1-cycle latency.
module alu_vec_aux
   import alu_vec_pkg::*;
#(
   parameter int W    = Q78_W,
   parameter int FRAC = Q78_FRAC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] data_a,
   input  logic [W-1:0] data_b,
   input  logic [W-1:0] data_c,
   input  logic [2:0]   opcode,
   input  logic         flag_scalar,
   input  logic [31:0]  instance_num,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   logic [W-1:0] mul_p;
   logic         mul_v;
   logic [W:0]   add_s;
   logic [W:0]   sub_s;
   logic [W-1:0] nxt_result;
   logic [3:0]   nxt_flags;
   logic         lane_idle;

   q78_mul #(.W(W), .FRAC(FRAC)) u_mul (
      .a       (data_a),
      .b       (data_b),
      .product (mul_p),
      .ovf     (mul_v)
   );

   assign add_s     = {1'b0, data_a} + {1'b0, data_b};
   assign sub_s     = {1'b0, data_a} + {1'b0, ~data_b} + (W+1)'(1);
   assign lane_idle = flag_scalar && (instance_num != 32'd0);

   always_comb begin
      nxt_result = '0;
      nxt_flags  = '0;
      case (opcode)
         OP_MUL: begin
            nxt_result       = mul_p;
            nxt_flags[FLG_V] = mul_v;
         end
         OP_SUB: begin
            nxt_result       = sub_s[W-1:0];
            nxt_flags[FLG_C] = sub_s[W];
            nxt_flags[FLG_V] = (data_a[W-1] != data_b[W-1]) && (sub_s[W-1] != data_a[W-1]);
         end
         OP_ADD: begin
            nxt_result       = add_s[W-1:0];
            nxt_flags[FLG_C] = add_s[W];
            nxt_flags[FLG_V] = (data_a[W-1] == data_b[W-1]) && (add_s[W-1] != data_a[W-1]);
         end
         OP_SET: nxt_result = data_c;
         default: ;
      endcase
      if (opcode == OP_MUL || opcode == OP_SUB || opcode == OP_ADD || opcode == OP_SET) begin
         nxt_flags[FLG_N] = nxt_result[W-1];
         nxt_flags[FLG_Z] = (nxt_result == '0);
      end
      if (lane_idle) begin
         nxt_result = data_a;
         nxt_flags  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         flags  <= '0;
      end else begin
         result <= nxt_result;
         flags  <= nxt_flags;
      end
   end

endmodule

// File: tb/tb_alu_vec_aux.sv
// Self-checking bench for alu_vec_aux: directed table vectors plus random ops against an arithmetic model.
module tb_alu_vec_aux;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_a, data_b, data_c;
   logic [2:0]  opcode;
   logic        flag_scalar;
   logic [31:0] instance_num;
   logic [15:0] result;
   logic [3:0]  flags;

   int total = 0;
   int bad   = 0;

   alu_vec_aux dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_a       (data_a),
      .data_b       (data_b),
      .data_c       (data_c),
      .opcode       (opcode),
      .flag_scalar  (flag_scalar),
      .instance_num (instance_num),
      .result       (result),
      .flags        (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] exp_r, input logic [3:0] exp_f);
      total++;
      assert (result === exp_r) else begin
         bad++;
         $error("FAIL %s result got=%h exp=%h", tag, result, exp_r);
      end
      total++;
      assert (flags === exp_f) else begin
         bad++;
         $error("FAIL %s flags got=%b exp=%b", tag, flags, exp_f);
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic fs, input logic [31:0] inst);
      @(negedge clk);
      opcode = op; data_a = a; data_b = b; data_c = c;
      flag_scalar = fs; instance_num = inst;
      @(posedge clk);
      #1;
   endtask

   // Reference from the arithmetic meaning of each op, using wide integers.
   function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic fs, input logic [31:0] inst,
                                 output logic [15:0] r, output logic [3:0] f);
      int sa, sb, p, t;
      int unsigned ua, ub;
      logic v, cy, valid;
      sa = int'($signed(a)); sb = int'($signed(b));
      ua = int'(a); ub = int'(b);
      r = 16'h0; f = 4'h0; v = 1'b0; cy = 1'b0; valid = 1'b1;
      if (fs && inst != 0) begin
         r = a;
         return;
      end
      case (op)
         3'd0: begin
            p = sa * sb;
            r = 16'(p >>> 8);
            v = (p < -(1 << 23)) || (p > (1 << 23) - 1);
         end
         3'd1: begin
            t = sa - sb;
            r = 16'(t);
            v = (t < -32768) || (t > 32767);
            cy = (ua >= ub);
         end
         3'd2: begin
            t = sa + sb;
            r = 16'(t);
            v = (t < -32768) || (t > 32767);
            cy = ((ua + ub) > 65535);
         end
         3'd7: r = c;
         default: valid = 1'b0;
      endcase
      if (valid) f = {v, r[15], (r == 16'h0), cy};
   endfunction

   initial begin
      logic [15:0] er;
      logic [3:0]  ef;
      logic [2:0]  rop;
      logic [15:0] ra, rb, rc;
      logic        rfs;
      logic [31:0] rinst;

      rst_n = 1'b0;
      data_a = '0; data_b = '0; data_c = '0; opcode = '0;
      flag_scalar = 1'b0; instance_num = '0;
      #2;
      check("reset_initial", 16'h0000, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      step(3'b010, 16'h0280, 16'h0280, 16'h0, 1'b0, 32'd0); check("add0", 16'h0500, 4'b0000);
      step(3'b010, 16'h01C0, 16'h00E0, 16'h0, 1'b0, 32'd0); check("add1", 16'h02A0, 4'b0000);
      step(3'b010, 16'hFC80, 16'h0500, 16'h0, 1'b0, 32'd0); check("add2", 16'h0180, 4'b0001);
      step(3'b010, 16'h7F00, 16'h0200, 16'h0, 1'b0, 32'd0); check("add3", 16'h8100, 4'b1100);
      step(3'b001, 16'h0F00, 16'h0800, 16'h0, 1'b0, 32'd0); check("sub0", 16'h0700, 4'b0001);
      step(3'b001, 16'h0180, 16'h01C0, 16'h0, 1'b0, 32'd0); check("sub1", 16'hFFC0, 4'b0100);
      step(3'b001, 16'h00C0, 16'hFFA0, 16'h0, 1'b0, 32'd0); check("sub2", 16'h0120, 4'b0000);
      step(3'b001, 16'hFF40, 16'h0040, 16'h0, 1'b0, 32'd0); check("sub3", 16'hFF00, 4'b0101);
      step(3'b000, 16'h0180, 16'hFE40, 16'h0, 1'b0, 32'd0); check("mul0", 16'hFD60, 4'b0100);
      step(3'b000, 16'h0140, 16'h0180, 16'h0, 1'b0, 32'd0); check("mul1", 16'h01E0, 4'b0000);
      step(3'b000, 16'hFD00, 16'h0080, 16'h0, 1'b0, 32'd0); check("mul2", 16'hFE80, 4'b0100);
      step(3'b000, 16'h7F00, 16'h7F00, 16'h0, 1'b0, 32'd0); check("mul3", 16'h0100, 4'b1000);
      step(3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 32'd0); check("set0", 16'h0000, 4'b0010);
      step(3'b111, 16'h1234, 16'h5678, 16'hFF00, 1'b0, 32'd0); check("set1", 16'hFF00, 4'b0100);
      step(3'b101, 16'h0280, 16'h0280, 16'hFF00, 1'b0, 32'd0); check("rsvd", 16'h0000, 4'b0000);
      step(3'b010, 16'h0280, 16'h0280, 16'h0, 1'b1, 32'd0); check("scalar_l0", 16'h0500, 4'b0000);
      step(3'b010, 16'h0280, 16'h0280, 16'h0, 1'b1, 32'd3); check("scalar_l3", 16'h0280, 4'b0000);

      // Asynchronous reset mid-operation, checked between clock edges.
      step(3'b010, 16'h0100, 16'h0100, 16'h0, 1'b0, 32'd0); check("pre_reset", 16'h0200, 4'b0000);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", 16'h0000, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b001, 16'h0F00, 16'h0800, 16'h0, 1'b0, 32'd0); check("post_reset", 16'h0700, 4'b0001);

      // Back-to-back random ops, one per cycle.
      for (int i = 0; i < 300; i++) begin
         rop   = 3'($urandom_range(0, 7));
         ra    = 16'($urandom);
         rb    = 16'($urandom);
         rc    = 16'($urandom);
         rfs   = ($urandom_range(0, 5) == 0);
         rinst = 32'($urandom_range(0, 3));
         if (i % 40 == 0) begin
            ra = 16'h7FFF; rb = (i % 80 == 0) ? 16'h8000 : 16'hFFFF;
         end
         step(rop, ra, rb, rc, rfs, rinst);
         model(rop, ra, rb, rc, rfs, rinst, er, ef);
         check($sformatf("rand%0d_op%0d", i, rop), er, ef);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
